program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Boot-time sequencer that writes a DEPTH-word program image into RAM through the
//  shared 8-bit bus, using the MAR and RAM bus-read strobes.
//  Sits beside the control unit. While loading it owns the bus and holds the CPU
//  in a stall. It then pulses a CPU reset so that execution starts from PC=0.
//  Lets the FPGA boot a program without the manual programming switches.
// PARAMETERS
//  DEPTH      16              words to load; addresses 0..DEPTH-1
//  ADDR_W     4               MAR address width; DEPTH <= 2**ADDR_W
//  DATA_W     8               bus/RAM word width
//  INIT_FILE  "program.hex"   $readmemh image, DEPTH words
//  AUTO_LOAD  1               1: start a load on the first cycle after rst deasserts
// PORTS
//  clk                input   1       CPU datapath clock; same clock as MAR/RAM
//  rst                input   1       synchronous, active-high reset
//  start              input   1       level; sampled in IDLE/DONE; starts a load
//  cpu_hold           output  1       high while loading; top gates all control-unit strobes low
//  cpu_rst            output  1       one-cycle pulse after the last word; ORed into CPU reset
//  bus_drive_en       output  1       loader drives bus_data onto the bus (tri-state enable)
//  bus_data           output  DATA_W  value driven when bus_drive_en=1, else 0
//  mar_read_from_bus  output  1       MAR latches bus[ADDR_W-1:0] at next clk edge
//  ram_read_from_bus  output  1       RAM[MAR] latches bus at next clk edge
//  load_addr          output  ADDR_W  address currently being written
//  done               output  1       high in DONE; stays high until next load/reset
// BEHAVIOUR
//  Reset: state=IDLE, load_addr=0; every output is 0. rst wins over all other inputs.
//  States: IDLE, SET_ADDR, WRITE, RELEASE, DONE.
//  - IDLE: all outputs 0.
//      -> SET_ADDR if start=1, or if this is the first post-reset cycle and AUTO_LOAD=1.
//  - SET_ADDR: cpu_hold=1, bus_drive_en=1, mar_read_from_bus=1.
//      bus_data = zero-extended load_addr. Always -> WRITE.
//  - WRITE: cpu_hold=1, bus_drive_en=1, ram_read_from_bus=1, bus_data=image[load_addr].
//      If load_addr==DEPTH-1: -> RELEASE and load_addr<=0.
//      Else: load_addr<=load_addr+1 and -> SET_ADDR.
//  - RELEASE: cpu_hold=1, cpu_rst=1, bus_drive_en=0. Always -> DONE.
//  - DONE: done=1, other outputs 0. start=1 -> SET_ADDR (reload from address 0).
//  Outputs are a Moore decode of the state, registered so they are glitch-free.
//  mar_read_from_bus and ram_read_from_bus are never high in the same cycle.
//  Timing: 2 cycles per word. start seen in IDLE at edge N gives SET_ADDR at N+1.
//      RELEASE at N+1+2*DEPTH, DONE at N+2+2*DEPTH. DEPTH=16: 32 load cycles.
//  start during SET_ADDR, WRITE or RELEASE is ignored; a load is never restarted mid-sequence.
//  load_addr wraps to 0 only through the WRITE->RELEASE path. It never exceeds DEPTH-1.
//  rst mid-load: the next cycle is IDLE with outputs 0. RAM is left partially written.
//      With AUTO_LOAD=1 a full reload restarts from address 0.
//  Image stored as reg [DATA_W-1:0] mem[DEPTH]; read combinationally from load_addr.
//  Any image word with X is a synthesis error, not a runtime error.
// TESTING
//  1. rst=1 for 3 cycles, AUTO_LOAD=0 -> all outputs 0, load_addr=0, state stays IDLE.
//  2. Image 0..15 = 8'h10+i, start pulse -> 32 cycles alternating MAR/RAM strobes.
//     Bus sequence 00,10,01,11,...,0F,1F; cpu_rst 1 cycle; done=1; RAM model matches image.
//  3. start held high through the load -> exactly one load; in DONE a held start triggers reload.
//  4. rst asserted in WRITE at load_addr=7 -> next cycle all outputs 0.
//     Restart writes from address 0; final RAM is the full image.
//  5. AUTO_LOAD=1 -> SET_ADDR on the first cycle after rst drops with start=0.
//     done after 34 cycles.
//  6. Assertions each cycle: bus_drive_en==0 implies bus_data==0.
//     !(mar_read && ram_read); cpu_hold=1 in every state except IDLE/DONE.

Source files
------------

// File: rtl/program_loader.sv
// Boot-time loader: copies a DEPTH-word image into RAM over the shared bus (MAR strobe, then RAM strobe),
// holds the CPU while doing so, then pulses a CPU reset. The image comes from the INIT_IMAGE parameter.
module program_loader #(
   parameter int                        DEPTH      = 16,
   parameter int                        ADDR_W     = 4,
   parameter int                        DATA_W     = 8,
   parameter logic [DEPTH*DATA_W-1:0]   INIT_IMAGE = '0,
   parameter bit                        AUTO_LOAD  = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   output logic              o_cpu_hold,
   output logic              o_cpu_rst,
   output logic              o_bus_drive_en,
   output logic [DATA_W-1:0] o_bus_data,
   output logic              o_mar_read_from_bus,
   output logic              o_ram_read_from_bus,
   output logic [ADDR_W-1:0] o_load_addr,
   output logic              o_done,
   output logic [2:0]        o_state
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_SET_ADDR = 3'd1;
   localparam logic [2:0] S_WRITE    = 3'd2;
   localparam logic [2:0] S_RELEASE  = 3'd3;
   localparam logic [2:0] S_DONE     = 3'd4;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   logic [2:0]        r_state;
   logic [ADDR_W-1:0] r_load_addr;
   logic              r_first;
   logic              r_cpu_hold;
   logic              r_cpu_rst;
   logic              r_bus_drive_en;
   logic [DATA_W-1:0] r_bus_data;
   logic              r_mar_read;
   logic              r_ram_read;
   logic              r_done;

   logic [2:0]        w_state_nxt;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic [DATA_W-1:0] w_addr_ext;
   logic [DATA_W-1:0] w_image_word;
   logic [DATA_W-1:0] w_bus_nxt;
   logic              w_go;

   logic [DATA_W-1:0] mem [DEPTH];

   for (genvar g = 0; g < DEPTH; g++) begin : g_image
      assign mem[g] = INIT_IMAGE[g*DATA_W +: DATA_W];
   end

   // A load begins on start, or unprompted on the first cycle out of reset when AUTO_LOAD is set.
   assign w_go = i_start || (AUTO_LOAD && r_first);

   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_load_addr;
      case (r_state)
         S_IDLE: begin
            if (w_go) begin
               w_state_nxt = S_SET_ADDR;
               w_addr_nxt  = '0;
            end
         end
         S_SET_ADDR: begin
            w_state_nxt = S_WRITE;
         end
         S_WRITE: begin
            if (r_load_addr == LAST_ADDR) begin
               w_state_nxt = S_RELEASE;
               w_addr_nxt  = '0;
            end else begin
               w_state_nxt = S_SET_ADDR;
               w_addr_nxt  = r_load_addr + 1'b1;
            end
         end
         S_RELEASE: begin
            w_state_nxt = S_DONE;
         end
         S_DONE: begin
            if (i_start) begin
               w_state_nxt = S_SET_ADDR;
               w_addr_nxt  = '0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_addr_nxt  = '0;
         end
      endcase
   end

   always_comb begin
      w_addr_ext                = '0;
      w_addr_ext[ADDR_W-1:0]    = w_addr_nxt;
   end

   assign w_image_word = mem[w_addr_nxt];

   // Bus value is decoded from the next state so the registered outputs line up with r_state.
   always_comb begin
      w_bus_nxt = '0;
      case (w_state_nxt)
         S_SET_ADDR: w_bus_nxt = w_addr_ext;
         S_WRITE:    w_bus_nxt = w_image_word;
         default:    w_bus_nxt = '0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state        <= S_IDLE;
         r_load_addr    <= '0;
         r_first        <= 1'b1;
         r_cpu_hold     <= 1'b0;
         r_cpu_rst      <= 1'b0;
         r_bus_drive_en <= 1'b0;
         r_bus_data     <= '0;
         r_mar_read     <= 1'b0;
         r_ram_read     <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_load_addr    <= w_addr_nxt;
         r_first        <= 1'b0;
         r_cpu_hold     <= (w_state_nxt == S_SET_ADDR) || (w_state_nxt == S_WRITE) ||
                           (w_state_nxt == S_RELEASE);
         r_cpu_rst      <= (w_state_nxt == S_RELEASE);
         r_bus_drive_en <= (w_state_nxt == S_SET_ADDR) || (w_state_nxt == S_WRITE);
         r_bus_data     <= w_bus_nxt;
         r_mar_read     <= (w_state_nxt == S_SET_ADDR);
         r_ram_read     <= (w_state_nxt == S_WRITE);
         r_done         <= (w_state_nxt == S_DONE);
      end
   end

   assign o_cpu_hold          = r_cpu_hold;
   assign o_cpu_rst           = r_cpu_rst;
   assign o_bus_drive_en      = r_bus_drive_en;
   assign o_bus_data          = r_bus_data;
   assign o_mar_read_from_bus = r_mar_read;
   assign o_ram_read_from_bus = r_ram_read;
   assign o_load_addr         = r_load_addr;
   assign o_done              = r_done;
   assign o_state             = r_state;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: one manual-start instance, one auto-load instance,
// a bus-driven MAR/RAM model and per-cycle invariant checks.
module tb_program_loader;

   localparam int DEPTH = 16;

   function automatic logic [DEPTH*8-1:0] mk_image();
      logic [DEPTH*8-1:0] v;
      v = '0;
      for (int i = 0; i < DEPTH; i++) v[i*8 +: 8] = 8'(8'h10 + i);
      return v;
   endfunction

   localparam logic [DEPTH*8-1:0] IMAGE = mk_image();

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       a_rst, a_start, a_hold, a_cpu_rst, a_drive, a_mar, a_ram, a_done;
   logic [7:0] a_bus;
   logic [3:0] a_addr;
   logic [2:0] a_state;
   logic       b_rst, b_start, b_hold, b_cpu_rst, b_drive, b_mar, b_ram, b_done;
   logic [7:0] b_bus;
   logic [3:0] b_addr;
   logic [2:0] b_state;

   int errors = 0;
   int checks = 0;
   int pulses = 0;
   int pulses_before;
   int n;

   logic       ram_clear;
   logic [3:0] tb_mar;
   logic [7:0] tb_ram [DEPTH];

   program_loader #(.DEPTH(DEPTH), .ADDR_W(4), .DATA_W(8), .INIT_IMAGE(IMAGE), .AUTO_LOAD(1'b0)) u_dut (
      .i_clk(clk), .i_rst(a_rst), .i_start(a_start),
      .o_cpu_hold(a_hold), .o_cpu_rst(a_cpu_rst), .o_bus_drive_en(a_drive), .o_bus_data(a_bus),
      .o_mar_read_from_bus(a_mar), .o_ram_read_from_bus(a_ram), .o_load_addr(a_addr),
      .o_done(a_done), .o_state(a_state)
   );

   program_loader #(.DEPTH(DEPTH), .ADDR_W(4), .DATA_W(8), .INIT_IMAGE(IMAGE), .AUTO_LOAD(1'b1)) u_auto (
      .i_clk(clk), .i_rst(b_rst), .i_start(b_start),
      .o_cpu_hold(b_hold), .o_cpu_rst(b_cpu_rst), .o_bus_drive_en(b_drive), .o_bus_data(b_bus),
      .o_mar_read_from_bus(b_mar), .o_ram_read_from_bus(b_ram), .o_load_addr(b_addr),
      .o_done(b_done), .o_state(b_state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // MAR/RAM as the datapath sees them: both latch the bus on the edge after their strobe.
   always @(posedge clk) begin
      if (ram_clear) begin
         for (int k = 0; k < DEPTH; k++) tb_ram[k] <= 8'hEE;
      end else begin
         if (a_mar) tb_mar <= a_bus[3:0];
         if (a_ram) tb_ram[tb_mar] <= a_bus;
      end
   end

   always @(negedge clk) begin
      chk("a_bus_zero_when_released", 32'(a_drive ? 8'h00 : a_bus), 32'(0));
      chk("a_strobes_exclusive", 32'(a_mar & a_ram), 32'(0));
      chk("a_hold_vs_state", 32'(a_hold), 32'(a_state == 3'd1 || a_state == 3'd2 || a_state == 3'd3));
      chk("b_bus_zero_when_released", 32'(b_drive ? 8'h00 : b_bus), 32'(0));
      chk("b_strobes_exclusive", 32'(b_mar & b_ram), 32'(0));
      chk("b_hold_vs_state", 32'(b_hold), 32'(b_state == 3'd1 || b_state == 3'd2 || b_state == 3'd3));
      if (a_cpu_rst) pulses++;
   end

   initial begin
      a_rst = 1'b1; a_start = 1'b0;
      b_rst = 1'b1; b_start = 1'b0;
      ram_clear = 1'b1;
      tb_mar = 4'h0;

      // reset held for 3 cycles
      repeat (3) step();
      ram_clear = 1'b0;
      chk("rst_state", 32'(a_state), 32'(0));
      chk("rst_outputs", 32'({a_hold, a_cpu_rst, a_drive, a_mar, a_ram, a_done}), 32'(0));
      chk("rst_bus", 32'(a_bus), 32'(0));
      chk("rst_addr", 32'(a_addr), 32'(0));
      a_rst = 1'b0;
      repeat (2) step();
      chk("idle_no_autoload", 32'(a_state), 32'(0));
      chk("idle_done_low", 32'(a_done), 32'(0));

      // full load from a start pulse
      a_start = 1'b1;
      step();
      a_start = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         chk("set_state", 32'(a_state), 32'(1));
         chk("set_strobes", 32'({a_mar, a_ram, a_drive}), 32'(3'b101));
         chk("set_bus", 32'(a_bus), 32'(i));
         chk("set_addr", 32'(a_addr), 32'(i));
         step();
         chk("write_state", 32'(a_state), 32'(2));
         chk("write_strobes", 32'({a_mar, a_ram, a_drive}), 32'(3'b011));
         chk("write_bus", 32'(a_bus), 32'(8'h10 + i));
         chk("write_addr", 32'(a_addr), 32'(i));
         step();
      end
      chk("release_state", 32'(a_state), 32'(3));
      chk("release_outputs", 32'({a_hold, a_cpu_rst, a_drive, a_done}), 32'(4'b1100));
      chk("release_bus", 32'(a_bus), 32'(0));
      chk("release_addr", 32'(a_addr), 32'(0));
      step();
      chk("done_state", 32'(a_state), 32'(4));
      chk("done_outputs", 32'({a_hold, a_cpu_rst, a_drive, a_done}), 32'(4'b0001));
      step();
      chk("done_sticky", 32'(a_done), 32'(1));
      chk("one_cpu_rst_pulse", 32'(pulses), 32'(1));
      for (int i = 0; i < DEPTH; i++) chk("ram_after_load", 32'(tb_ram[i]), 32'(8'h10 + i));

      // start held high: no mid-load restart, reload from DONE
      ram_clear = 1'b1;
      step();
      ram_clear = 1'b0;
      a_start = 1'b1;
      step();
      pulses_before = pulses;
      chk("held_set0", 32'({a_state, a_addr}), 32'({3'd1, 4'd0}));
      step();
      chk("held_write0", 32'({a_state, a_addr}), 32'({3'd2, 4'd0}));
      repeat (31) step();
      chk("held_release", 32'(a_state), 32'(3));
      step();
      chk("held_done", 32'({a_state, a_done}), 32'({3'd4, 1'b1}));
      step();
      chk("held_reload", 32'({a_state, a_addr}), 32'({3'd1, 4'd0}));
      a_start = 1'b0;
      n = 0;
      while (!a_done && n < 100) begin step(); n++; end
      chk("held_reload_cycles", 32'(n), 32'(33));
      step();
      chk("held_two_loads", 32'(pulses - pulses_before), 32'(2));
      for (int i = 0; i < DEPTH; i++) chk("ram_after_reload", 32'(tb_ram[i]), 32'(8'h10 + i));

      // reset during WRITE of address 7
      ram_clear = 1'b1;
      a_start = 1'b1;
      step();
      ram_clear = 1'b0;
      a_start = 1'b0;
      repeat (15) step();
      chk("mid_write7", 32'({a_state, a_addr, a_ram}), 32'({3'd2, 4'd7, 1'b1}));
      a_rst = 1'b1;
      step();
      chk("mid_rst_state", 32'(a_state), 32'(0));
      chk("mid_rst_outputs", 32'({a_hold, a_cpu_rst, a_drive, a_mar, a_ram, a_done}), 32'(0));
      chk("mid_rst_bus_addr", 32'({a_bus, a_addr}), 32'(0));
      chk("partial_ram6", 32'(tb_ram[6]), 32'(8'h16));
      chk("partial_ram7", 32'(tb_ram[7]), 32'(8'h17));
      chk("partial_ram8", 32'(tb_ram[8]), 32'(8'hEE));
      a_rst = 1'b0;
      a_start = 1'b1;
      step();
      chk("restart_set0", 32'({a_state, a_addr}), 32'({3'd1, 4'd0}));
      a_start = 1'b0;
      n = 0;
      while (!a_done && n < 100) begin step(); n++; end
      chk("restart_cycles", 32'(n), 32'(33));
      for (int i = 0; i < DEPTH; i++) chk("ram_after_restart", 32'(tb_ram[i]), 32'(8'h10 + i));

      // auto-load instance: load starts on the first cycle out of reset
      b_rst = 1'b0;
      step();
      n = 1;
      chk("auto_set0", 32'({b_state, b_addr}), 32'({3'd1, 4'd0}));
      chk("auto_set0_outputs", 32'({b_hold, b_drive, b_mar, b_bus}), 32'({3'b111, 8'h00}));
      while (!b_done && n < 100) begin step(); n++; end
      chk("auto_done_cycles", 32'(n), 32'(34));
      repeat (3) step();
      chk("auto_stays_done", 32'({b_state, b_done}), 32'({3'd4, 1'b1}));
      b_rst = 1'b1;
      step();
      chk("auto_rst_idle", 32'({b_state, b_hold, b_done}), 32'({3'd0, 2'b00}));
      b_rst = 1'b0;
      step();
      chk("auto_reload_set0", 32'({b_state, b_addr}), 32'({3'd1, 4'd0}));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
